lfsr_prbs_gen_chk: RTL and testbench

//  Parametrised Galois PRBS generator plus self-synchronising lock checker for link/BIST test.

---
 rtl/lfsr_pkg.sv | 47 ++++
 rtl/lfsr_lock_checker.sv | 144 ++++++++++++++
 rtl/lfsr_prbs_gen_chk.sv | 95 +++++++++
 tb/tb_lfsr_prbs_gen_chk.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : lfsr_pkg                                                   |
// | Description : Shared types and the Galois next-state function used by    |
// |               both the PRBS generator and the lock checker, so the two   |
// |               halves can never disagree on the sequence.                 |
// | Contents    : LFSR_MAX_W   widest LFSR supported by lfsr_next            |
// |               chk_state_t  checker FSM state encoding                    |
// |               lfsr_next    one Galois step, optional de Bruijn zero state |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package lfsr_pkg;

  localparam int LFSR_MAX_W = 64;

  typedef enum logic [1:0] {
    CHK_UNLOCKED = 2'd0,
    CHK_CHECKING = 2'd1,
    CHK_LOCKED   = 2'd2
  } chk_state_t;

  // One Galois step on an LFSR of 'width' bits, carried in a LFSR_MAX_W-bit
  // container (callers zero-extend in and truncate out). Bits at or above
  // 'width' are forced to zero in the result.
  // Feedback is the MSB; with debruijn set it is inverted when all lower bits
  // are zero, which splices the all-zero state into the cycle.
  // poly[0] is required to be 1, so the shifted-in zero at bit 0 becomes fb.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] r,
    input logic [LFSR_MAX_W-1:0] poly,
    input logic                  debruijn,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] full_mask;
    logic [LFSR_MAX_W-1:0] low_mask;
    logic [LFSR_MAX_W-1:0] msb_mask;
    logic                  fb;
    full_mask = (width >= LFSR_MAX_W) ? {LFSR_MAX_W{1'b1}}
                                      : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
    msb_mask  = LFSR_MAX_W'(1) << (width - 1);
    low_mask  = msb_mask - LFSR_MAX_W'(1);
    fb        = (|(r & msb_mask)) ^ (debruijn & ((r & low_mask) == '0));
    return ((r << 1) ^ (poly & {LFSR_MAX_W{fb}})) & full_mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_lock_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lfsr_lock_checker                                          |
// | Description : Self-synchronising PRBS checker. Loads a received word as  |
// |               the reference, counts consecutive predicted matches until  |
// |               lock, then free-runs its own reference and counts word     |
// |               errors; enough consecutive misses drop lock.               |
// | Ports       : clk           clock, rising edge                           |
// |               i_rst         asynchronous active-high reset               |
// |               i_soft_reset  sync clear: UNLOCKED, counters and errors 0  |
// |               i_debruijn    zero-state insertion select for prediction   |
// |               i_chk_valid   i_chk_data holds a word this cycle           |
// |               i_chk_data    received PRBS word                           |
// |               o_lock        registered, high while LOCKED                |
// |               o_err_cnt     saturating mismatch count while LOCKED       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lfsr_lock_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(8'h1D),
  parameter int               LOCK_CNT   = 5,
  parameter int               UNLOCK_CNT = 3,
  parameter int               ERR_W      = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_soft_reset,
  input  logic             i_debruijn,
  input  logic             i_chk_valid,
  input  logic [WIDTH-1:0] i_chk_data,
  output logic             o_lock,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam logic [7:0] C_LOCK_CNT   = 8'(LOCK_CNT);
  localparam logic [7:0] C_UNLOCK_CNT = 8'(UNLOCK_CNT);

  chk_state_t       state_q, state_d;
  logic [WIDTH-1:0] chk_reg_q, chk_reg_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [7:0]       miss_cnt_q, miss_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             lock_q, lock_d;

  logic [WIDTH-1:0] w_exp;
  logic             w_match;
  logic [7:0]       w_match_inc;
  logic [7:0]       w_miss_inc;

  assign w_exp       = WIDTH'(lfsr_next(LFSR_MAX_W'(chk_reg_q), LFSR_MAX_W'(POLY),
                                        i_debruijn, WIDTH));
  assign w_match     = (i_chk_data == w_exp);
  assign w_match_inc = match_cnt_q + 8'd1;
  assign w_miss_inc  = miss_cnt_q + 8'd1;

  // State register
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= CHK_UNLOCKED;
      chk_reg_q   <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_cnt_q   <= '0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_reg_q   <= chk_reg_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_cnt_q   <= err_cnt_d;
      lock_q      <= lock_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d     = state_q;
    chk_reg_d   = chk_reg_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (i_soft_reset) begin
      state_d     = CHK_UNLOCKED;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      err_cnt_d   = '0;
    end else if (i_chk_valid) begin
      case (state_q)
        CHK_UNLOCKED: begin
          // An all-zero word is a lock-up state of the plain LFSR; never seed from it.
          if (!((i_chk_data == '0) && !i_debruijn)) begin
            chk_reg_d   = i_chk_data;
            match_cnt_d = '0;
            state_d     = CHK_CHECKING;
          end
        end
        CHK_CHECKING: begin
          if (w_match) begin
            chk_reg_d   = w_exp;
            match_cnt_d = w_match_inc;
            if (w_match_inc == C_LOCK_CNT) begin
              state_d    = CHK_LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            // Resync: take the received word as the new reference.
            chk_reg_d   = i_chk_data;
            match_cnt_d = '0;
          end
        end
        CHK_LOCKED: begin
          // Free-run the reference so errors are counted rather than absorbed.
          chk_reg_d = w_exp;
          if (w_match) begin
            miss_cnt_d = '0;
          end else begin
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            miss_cnt_d = w_miss_inc;
            if (w_miss_inc == C_UNLOCK_CNT) begin
              state_d = CHK_UNLOCKED;
            end
          end
        end
        default: begin
          state_d = CHK_UNLOCKED;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    lock_d = (state_d == CHK_LOCKED);
  end

  assign o_lock    = lock_q;
  assign o_err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_prbs_gen_chk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lfsr_prbs_gen_chk                                          |
// | Description : Galois PRBS generator with optional de Bruijn zero state,  |
// |               plus an independent self-synchronising lock checker.       |
// | Ports       : clk           clock, rising edge                           |
// |               i_rst         asynchronous active-high reset               |
// |               i_soft_reset  sync: gen <= seed, checker cleared           |
// |               i_seed        seed used by soft reset                      |
// |               i_debruijn    1: period 2^WIDTH, 0: period 2^WIDTH-1       |
// |               i_valid       advance the generator one step               |
// |               o_lfsr        generator state                              |
// |               o_lfsr_valid  high the cycle after a step or soft reset    |
// |               i_chk_valid   i_chk_data holds a word this cycle           |
// |               i_chk_data    received PRBS word                           |
// |               o_lock        checker locked                               |
// |               o_err_cnt     saturating word-error count while locked     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lfsr_prbs_gen_chk
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
  parameter int               LOCK_CNT     = 5,
  parameter int               UNLOCK_CNT   = 3,
  parameter int               ERR_W        = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_soft_reset,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_debruijn,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_lfsr,
  output logic             o_lfsr_valid,
  input  logic             i_chk_valid,
  input  logic [WIDTH-1:0] i_chk_data,
  output logic             o_lock,
  output logic [ERR_W-1:0] o_err_cnt
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             lfsr_valid_q, lfsr_valid_d;
  logic [WIDTH-1:0] w_lfsr_next;

  assign w_lfsr_next = WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(POLY),
                                        i_debruijn, WIDTH));

  always_comb begin
    lfsr_d       = lfsr_q;
    lfsr_valid_d = 1'b0;
    if (i_soft_reset) begin
      // A zero seed would lock up the plain LFSR, so fall back to the default.
      lfsr_d       = ((i_seed == '0) && !i_debruijn) ? DEFAULT_SEED : i_seed;
      lfsr_valid_d = 1'b1;
    end else if (i_valid) begin
      lfsr_d       = w_lfsr_next;
      lfsr_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_q       <= DEFAULT_SEED;
      lfsr_valid_q <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      lfsr_valid_q <= lfsr_valid_d;
    end
  end

  assign o_lfsr       = lfsr_q;
  assign o_lfsr_valid = lfsr_valid_q;

  lfsr_lock_checker #(
    .WIDTH      (WIDTH),
    .POLY       (POLY),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT),
    .ERR_W      (ERR_W)
  ) u_checker (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_soft_reset (i_soft_reset),
    .i_debruijn   (i_debruijn),
    .i_chk_valid  (i_chk_valid),
    .i_chk_data   (i_chk_data),
    .o_lock       (o_lock),
    .o_err_cnt    (o_err_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prbs_gen_chk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lfsr_prbs_gen_chk                                       |
// | Description : Self-checking bench: directed sequence/period/lock tests   |
// |               followed by randomized traffic, all checked against a      |
// |               behavioural model of the generator and checker.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_lfsr_prbs_gen_chk;

  localparam int LOCK   = 5;
  localparam int UNLOCK = 3;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_soft_reset = 1'b0;
  logic [7:0]  i_seed = '0;
  logic        i_debruijn = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  o_lfsr;
  logic        o_lfsr_valid;
  logic        i_chk_valid = 1'b0;
  logic [7:0]  i_chk_data = '0;
  logic        o_lock;
  logic [15:0] o_err_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Loopback stimulus control
  logic       lb = 1'b0;
  logic [7:0] cor = '0;

  // Reference model state
  logic [7:0] m_lfsr;
  logic       m_lval;
  int         m_st;     // 0 unlocked, 1 checking, 2 locked
  logic [7:0] m_reg;
  int         m_match, m_miss, m_err;

  always #5 clk = ~clk;

  lfsr_prbs_gen_chk dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_soft_reset (i_soft_reset),
    .i_seed       (i_seed),
    .i_debruijn   (i_debruijn),
    .i_valid      (i_valid),
    .o_lfsr       (o_lfsr),
    .o_lfsr_valid (o_lfsr_valid),
    .i_chk_valid  (i_chk_valid),
    .i_chk_data   (i_chk_data),
    .o_lock       (o_lock),
    .o_err_cnt    (o_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Polynomial view: multiply by x modulo the feedback polynomial, with the
  // de Bruijn tweak flipping the carry when the low seven bits are clear.
  function automatic logic [7:0] ref_next(input logic [7:0] r, input logic deb);
    int v;
    bit fb;
    fb = (r >= 8'd128) ^ (deb && ((r % 128) == 0));
    v  = (r * 2) % 256;
    if (fb) v = v ^ 'h1D;
    return v[7:0];
  endfunction

  task automatic model_reset();
    m_lfsr = 8'h01; m_lval = 1'b0;
    m_st = 0; m_reg = '0; m_match = 0; m_miss = 0; m_err = 0;
  endtask

  task automatic model_update();
    logic [7:0] e;
    if (i_soft_reset) begin
      m_lfsr = (i_seed == 0 && !i_debruijn) ? 8'h01 : i_seed;
      m_lval = 1'b1;
    end else if (i_valid) begin
      m_lfsr = ref_next(m_lfsr, i_debruijn);
      m_lval = 1'b1;
    end else begin
      m_lval = 1'b0;
    end
    if (i_soft_reset) begin
      m_st = 0; m_match = 0; m_miss = 0; m_err = 0;
    end else if (i_chk_valid) begin
      e = ref_next(m_reg, i_debruijn);
      if (m_st == 0) begin
        if (!(i_chk_data == 0 && !i_debruijn)) begin
          m_reg = i_chk_data; m_match = 0; m_st = 1;
        end
      end else if (m_st == 1) begin
        if (i_chk_data == e) begin
          m_reg = e; m_match++;
          if (m_match == LOCK) begin m_st = 2; m_miss = 0; end
        end else begin
          m_reg = i_chk_data; m_match = 0;
        end
      end else begin
        m_reg = e;
        if (i_chk_data == e) m_miss = 0;
        else begin
          if (m_err < 65535) m_err++;
          m_miss++;
          if (m_miss == UNLOCK) m_st = 0;
        end
      end
    end
  endtask

  task automatic step();
    if (lb) begin
      i_chk_valid = o_lfsr_valid;
      i_chk_data  = o_lfsr ^ cor;
    end
    @(posedge clk);
    model_update();
    #1;
    check("lfsr", o_lfsr, m_lfsr);
    check("lfsr_valid", o_lfsr_valid, m_lval);
    check("lock", o_lock, (m_st == 2));
    check("err_cnt", o_err_cnt, m_err);
  endtask

  task automatic async_reset(input string tag);
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_lock"}, o_lock, 0);
    check({tag, "_err"}, o_err_cnt, 0);
    check({tag, "_lfsr"}, o_lfsr, 8'h01);
    check({tag, "_lval"}, o_lfsr_valid, 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_db [9];
    int cnt;
    int words;
    int lock_at;
    exp_db = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h1D};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_lfsr", o_lfsr, 8'h01);
    check("rst_lval", o_lfsr_valid, 0);
    check("rst_lock", o_lock, 0);
    check("rst_err", o_err_cnt, 0);
    i_rst = 1'b0;

    // De Bruijn sequence from the reset seed
    i_debruijn = 1'b1; i_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check("db_seq", o_lfsr, exp_db[i]);
    end

    // Plain LFSR: 0x80 goes straight to 0x1D
    i_valid = 1'b0;
    async_reset("rst2");
    i_debruijn = 1'b0; i_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 6) check("plain_80", o_lfsr, 8'h80);
      if (i == 7) check("plain_1d", o_lfsr, 8'h1D);
    end

    // Period measurements
    for (int d = 0; d < 2; d++) begin
      i_debruijn = d[0];
      i_valid = 1'b0; i_soft_reset = 1'b1; i_seed = 8'h01;
      step();
      i_soft_reset = 1'b0; i_valid = 1'b1;
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (o_lfsr != 8'h01 && cnt < 300);
      check(d ? "period_db" : "period_plain", cnt, d ? 256 : 255);
    end

    // Zero seed handling
    i_valid = 1'b0; i_debruijn = 1'b0; i_seed = 8'h00; i_soft_reset = 1'b1;
    step();
    check("seed0_plain", o_lfsr, 8'h01);
    i_debruijn = 1'b1;
    step();
    check("seed0_db", o_lfsr, 8'h00);
    i_soft_reset = 1'b0; i_valid = 1'b1;
    step();
    check("seed0_db_next", o_lfsr, 8'h1D);

    // Loopback lock: one load plus five matches
    i_valid = 1'b0; i_soft_reset = 1'b1; i_seed = 8'h5A;
    step();
    i_soft_reset = 1'b0; i_valid = 1'b1; lb = 1'b1; cor = '0;
    words = 0; lock_at = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (i_chk_valid) words++;
      if (o_lock && lock_at == 0) lock_at = words;
    end
    check("lock_words", lock_at, 6);
    check("lb_lock", o_lock, 1);
    check("lb_err", o_err_cnt, 0);

    // Two isolated corrupted words: counted, lock held
    cor = 8'h01; step(); cor = '0; repeat (4) step();
    cor = 8'h01; step(); cor = '0; repeat (4) step();
    check("cor2_err", o_err_cnt, 2);
    check("cor2_lock", o_lock, 1);

    // Three consecutive corrupted words drop lock, six clean words relock
    cor = 8'h01; repeat (3) step(); cor = '0;
    check("cor3_lock", o_lock, 0);
    check("cor3_err", o_err_cnt, 5);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!o_lock && cnt < 20);
    check("relock_words", cnt, 6);

    // Asynchronous reset while locked
    async_reset("rst_locked");
    lb = 1'b0; i_chk_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) lb = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 255) == 0) i_debruijn = ~i_debruijn;
      i_valid      = ($urandom_range(0, 3) != 0);
      i_soft_reset = ($urandom_range(0, 199) == 0);
      i_seed       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if (lb) begin
        cor = ($urandom_range(0, 39) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      end else begin
        i_chk_valid = $urandom_range(0, 1);
        i_chk_data  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      end
      step();
      if ($urandom_range(0, 999) == 0) async_reset("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
